// File: rtl/sobel_window_filter_if.sv
// Pixel stream bundle between the three-row line buffer and the Sobel filter,
// carrying the window input rows and the filtered gray output stream.
interface sobel_window_filter_if #(
    parameter int DATA_WIDTH = 12
);
    logic [DATA_WIDTH-1:0] row0_pixel;
    logic [DATA_WIDTH-1:0] row1_pixel;
    logic [DATA_WIDTH-1:0] row2_pixel;
    logic                  row2_pixel_valid;
    logic                  row2_pixel_edge;
    logic [DATA_WIDTH-1:0] pixel_out;
    logic                  pixel_out_valid;
    logic                  pixel_out_edge;

    modport master (
        output row0_pixel, row1_pixel, row2_pixel, row2_pixel_valid, row2_pixel_edge,
        input  pixel_out, pixel_out_valid, pixel_out_edge
    );

    modport slave (
        input  row0_pixel, row1_pixel, row2_pixel, row2_pixel_valid, row2_pixel_edge,
        output pixel_out, pixel_out_valid, pixel_out_edge
    );
endinterface

// File: rtl/sobel_window_filter.sv
// 3x3 Sobel magnitude filter on RGB444 rows, 3-cycle latency with an end-of-row flush slot.
// Optional binarised output when SOBEL_THRESHOLD_EN is defined.
module sobel_window_filter #(
    parameter int DATA_WIDTH = 12,
    parameter int WIDTH      = 640,
    parameter int MAG_SHIFT  = 3,
    parameter int THRESH     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    sobel_window_filter_if.slave  bus,
    output logic                  overrun
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {ST_RUN, ST_FLUSH} state_t;

    state_t         state_reg, state_next;
    logic [CW-1:0]  col_reg, col_next;
    logic           overrun_reg, overrun_next;
    logic           shift;
    logic           s1_valid_next, s1_border_next, s1_edge_next;

    // Window is indexed row*3 + column, column 0 = left, 2 = right (newest).
    logic [11:0]        win_reg  [9];
    logic [5:0]         gray_reg [9];
    logic [11:0]        row_in   [3];
    logic               s1_valid_reg, s1_border_reg, s1_edge_reg;
    logic               s2_valid_reg, s2_border_reg, s2_edge_reg;
    logic               s3_valid_reg, s3_border_reg, s3_edge_reg;
    logic signed [9:0]  gx_reg, gy_reg, gx_next, gy_next;
    logic [9:0]         abs_x, abs_y, mag, mag_shifted;
    logic [3:0]         m;
    logic [11:0]        pix_next;
    logic [11:0]        pixel_out_reg;
    logic               pixel_out_valid_reg, pixel_out_edge_reg;

    assign row_in[0] = bus.row0_pixel;
    assign row_in[1] = bus.row1_pixel;
    assign row_in[2] = bus.row2_pixel;

    function automatic logic [5:0] gray(input logic [11:0] p);
        return {2'b00, p[11:8]} + {1'b0, p[7:4], 1'b0} + {2'b00, p[3:0]};
    endfunction

    function automatic logic [9:0] wsum(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c);
        return {4'b0, a} + {3'b0, b, 1'b0} + {4'b0, c};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_RUN;
            col_reg     <= '0;
            overrun_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            col_reg     <= col_next;
            overrun_reg <= overrun_next;
        end
    end

    // The flush slot injects the right-border output for the last column of the row.
    always_comb begin
        state_next     = state_reg;
        col_next       = col_reg;
        overrun_next   = overrun_reg;
        shift          = 1'b0;
        s1_valid_next  = 1'b0;
        s1_border_next = 1'b0;
        s1_edge_next   = 1'b0;
        if (en) begin
            case (state_reg)
                ST_RUN: begin
                    if (bus.row2_pixel_valid) begin
                        shift          = 1'b1;
                        s1_valid_next  = (col_reg != '0);
                        s1_border_next = (col_reg == CW'(1));
                        if (bus.row2_pixel_edge) begin
                            col_next   = '0;
                            state_next = ST_FLUSH;
                        end else if (col_reg != CW'(WIDTH - 1)) begin
                            col_next = col_reg + CW'(1);
                        end
                    end
                end
                ST_FLUSH: begin
                    s1_valid_next  = 1'b1;
                    s1_border_next = 1'b1;
                    s1_edge_next   = 1'b1;
                    state_next     = ST_RUN;
                    if (bus.row2_pixel_valid) begin
                        overrun_next = 1'b1;
                    end
                end
                default: state_next = ST_RUN;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_win_row
            always_ff @(posedge clk) begin
                if (rst) begin
                    win_reg[gi*3 + 0] <= '0;
                    win_reg[gi*3 + 1] <= '0;
                    win_reg[gi*3 + 2] <= '0;
                end else if (shift) begin
                    win_reg[gi*3 + 0] <= win_reg[gi*3 + 1];
                    win_reg[gi*3 + 1] <= win_reg[gi*3 + 2];
                    win_reg[gi*3 + 2] <= row_in[gi];
                end
            end
        end

        for (genvar gi = 0; gi < 9; gi++) begin : g_gray
            always_ff @(posedge clk) begin
                if (rst) begin
                    gray_reg[gi] <= '0;
                end else if (en) begin
                    gray_reg[gi] <= gray(win_reg[gi]);
                end
            end
        end
    endgenerate

    // Taps: TL=0 TC=1 TR=2 / ML=3 MR=5 / BL=6 BC=7 BR=8.
    always_comb begin
        gx_next = $signed(wsum(gray_reg[2], gray_reg[5], gray_reg[8]))
                - $signed(wsum(gray_reg[0], gray_reg[3], gray_reg[6]));
        gy_next = $signed(wsum(gray_reg[6], gray_reg[7], gray_reg[8]))
                - $signed(wsum(gray_reg[0], gray_reg[1], gray_reg[2]));
    end

    always_comb begin
        abs_x       = gx_reg[9] ? 10'(-gx_reg) : 10'(gx_reg);
        abs_y       = gy_reg[9] ? 10'(-gy_reg) : 10'(gy_reg);
        mag         = abs_x + abs_y;
        mag_shifted = mag >> MAG_SHIFT;
        m           = (mag_shifted > 10'd15) ? 4'hF : mag_shifted[3:0];
        pix_next    = 12'h000;
        if (!s3_border_reg) begin
`ifdef SOBEL_THRESHOLD_EN
            pix_next = (int'(m) >= THRESH) ? 12'hFFF : 12'h000;
`else
            pix_next = {m, m, m};
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg  <= 1'b0;
            s1_border_reg <= 1'b0;
            s1_edge_reg   <= 1'b0;
            s2_valid_reg  <= 1'b0;
            s2_border_reg <= 1'b0;
            s2_edge_reg   <= 1'b0;
            s3_valid_reg  <= 1'b0;
            s3_border_reg <= 1'b0;
            s3_edge_reg   <= 1'b0;
            gx_reg        <= '0;
            gy_reg        <= '0;
        end else if (en) begin
            s1_valid_reg  <= s1_valid_next;
            s1_border_reg <= s1_border_next;
            s1_edge_reg   <= s1_edge_next;
            s2_valid_reg  <= s1_valid_reg;
            s2_border_reg <= s1_border_reg;
            s2_edge_reg   <= s1_edge_reg;
            s3_valid_reg  <= s2_valid_reg;
            s3_border_reg <= s2_border_reg;
            s3_edge_reg   <= s2_edge_reg;
            gx_reg        <= gx_next;
            gy_reg        <= gy_next;
        end
    end

    // While stalled the output valid drops, so a held pixel is presented only once.
    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_out_reg       <= '0;
            pixel_out_valid_reg <= 1'b0;
            pixel_out_edge_reg  <= 1'b0;
        end else begin
            pixel_out_valid_reg <= en & s3_valid_reg;
            pixel_out_edge_reg  <= en & s3_valid_reg & s3_edge_reg;
            if (en) begin
                pixel_out_reg <= pix_next;
            end
        end
    end

    assign bus.pixel_out       = pixel_out_reg;
    assign bus.pixel_out_valid = pixel_out_valid_reg;
    assign bus.pixel_out_edge  = pixel_out_edge_reg;
    assign overrun             = overrun_reg;
endmodule
